add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_pkg.sv | 17 +
 rtl/add_arbiter_rr_pick.sv | 20 ++
 rtl/add_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the two-requester add arbiter: FSM encoding and requester count.
package add_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Index of the granted requester from a one-hot two-bit grant vector.
  function automatic logic grant_index(input logic [NUM_REQ-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Combinational two-way round-robin selector; prio names the preferred requester on a tie.
module rr_pick
  import add_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic               prio,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/add_arbiter.sv
// Arbitrates two add requesters onto one shared adder; one operation in flight at a time,
// released only when the adder reports the sum stored.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int ID_SIZE   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_add_1,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_add_2,
  input  logic [NUM_REQ*ID_SIZE-1:0]   req_id,
  output logic [DATA_SIZE-1:0]         add_1,
  output logic [DATA_SIZE-1:0]         add_2,
  output logic [ID_SIZE-1:0]           id_add,
  output logic                         a_valid_data,
  input  logic                         a_ready_data,
  input  logic                         sum_written,
  output logic                         res_src,
  output logic                         busy
);

  arb_state_e           state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 res_src_q, res_src_d;
  logic                 busy_q, busy_d;
  logic [DATA_SIZE-1:0] hold_add1_q, hold_add1_d;
  logic [DATA_SIZE-1:0] hold_add2_q, hold_add2_d;
  logic [ID_SIZE-1:0]   hold_id_q, hold_id_d;

  logic [DATA_SIZE-1:0] op1_arr [NUM_REQ];
  logic [DATA_SIZE-1:0] op2_arr [NUM_REQ];
  logic [ID_SIZE-1:0]   id_arr  [NUM_REQ];
  logic [NUM_REQ-1:0]   grant;
  logic                 g_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op1_arr[gi] = req_add_1[gi*DATA_SIZE +: DATA_SIZE];
      assign op2_arr[gi] = req_add_2[gi*DATA_SIZE +: DATA_SIZE];
      assign id_arr[gi]  = req_id[gi*ID_SIZE +: ID_SIZE];
    end
  endgenerate

  rr_pick u_rr_pick (
    .req_valid (req_valid),
    .prio      (prio_q),
    .grant     (grant)
  );

  assign g_idx = grant_index(grant);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    res_src_d   = res_src_q;
    hold_add1_d = hold_add1_q;
    hold_add2_d = hold_add2_q;
    hold_id_d   = hold_id_q;
    unique case (state_q)
      ST_IDLE: begin
        // Grant is already qualified by req_valid, so any grant bit is an acceptance.
        if (|grant) begin
          hold_add1_d = op1_arr[g_idx];
          hold_add2_d = op2_arr[g_idx];
          hold_id_d   = id_arr[g_idx];
          res_src_d   = g_idx;
          prio_d      = ~g_idx;
          state_d     = ST_OFFER;
        end
      end
      ST_OFFER: if (a_ready_data) state_d = ST_WAIT;
      ST_WAIT:  if (sum_written)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prio_q      <= 1'b0;
      res_src_q   <= 1'b0;
      busy_q      <= 1'b0;
      hold_add1_q <= '0;
      hold_add2_q <= '0;
      hold_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      res_src_q   <= res_src_d;
      busy_q      <= busy_d;
      hold_add1_q <= hold_add1_d;
      hold_add2_q <= hold_add2_d;
      hold_id_q   <= hold_id_d;
    end
  end

  // rst_n gates the grant so nothing is offered to requesters while reset is held.
  assign req_ready    = (state_q == ST_IDLE && rst_n) ? grant : '0;
  assign a_valid_data = (state_q == ST_OFFER);
  assign add_1        = hold_add1_q;
  assign add_2        = hold_add2_q;
  assign id_add       = hold_id_q;
  assign res_src      = res_src_q;
  assign busy         = busy_q;

endmodule
